// File: rtl/ysyx_25040111_lsu_pkg.sv
// ============================================================================
//  Module   : ysyx_25040111_lsu_pkg
//  Purpose  : Shared widths, size/state encodings and packet type for the LSU
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25040111_lsu_pkg;

    localparam int XLEN   = 32;
    localparam int GPR_AW = 5;
    localparam int CSR_AW = 12;

    localparam logic [1:0] LSU_N = 2'b00;
    localparam logic [1:0] LSU_B = 2'b01;
    localparam logic [1:0] LSU_H = 2'b10;
    localparam logic [1:0] LSU_W = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_WB   = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic              men;
        logic [GPR_AW-1:0] ard;
        logic [XLEN-1:0]   rd;
        logic              gen;
        logic [CSR_AW-1:0] acsr;
        logic [XLEN-1:0]   csr;
        logic              sen;
        logic              write;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [1:0]        mask;
        logic              rsign;
    } lsu_pkt_t;

    function automatic logic lsu_misaligned(input logic [1:0] mask, input logic [1:0] a);
        return ((mask == LSU_H) && a[0]) || ((mask == LSU_W) && (a != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25040111_lsu_if.sv
// ============================================================================
//  Module   : ysyx_25040111_abt_if / ysyx_25040111_mem_if
//  Purpose  : Execute-to-LSU packet handshake and LSU data-bus interfaces
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_25040111_abt_if;
    logic        abt_valid;
    logic        abt_ready;
    logic        abt_men;
    logic [4:0]  abt_ard;
    logic [31:0] abt_rd;
    logic        abt_gen;
    logic [11:0] abt_acsr;
    logic [31:0] abt_csr;
    logic        abt_sen;
    logic        abt_write;
    logic [31:0] abt_addr;
    logic [31:0] abt_wdata;
    logic [1:0]  abt_mask;
    logic        abt_rsign;
    logic        abt_finish;

    // master = execute unit, slave = load/store stage
    modport master (
        output abt_valid, abt_men, abt_ard, abt_rd, abt_gen, abt_acsr, abt_csr,
               abt_sen, abt_write, abt_addr, abt_wdata, abt_mask, abt_rsign,
        input  abt_ready, abt_finish
    );
    modport slave (
        input  abt_valid, abt_men, abt_ard, abt_rd, abt_gen, abt_acsr, abt_csr,
               abt_sen, abt_write, abt_addr, abt_wdata, abt_mask, abt_rsign,
        output abt_ready, abt_finish
    );
endinterface

interface ysyx_25040111_mem_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );
    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_25040111_lsu_align.sv
// ============================================================================
//  Module   : ysyx_25040111_lsu_align
//  Purpose  : Store lane steering, load shift/extension and misalign check
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25040111_lsu_align
    import ysyx_25040111_lsu_pkg::*;
(
    input  logic [1:0]  mask_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        write_i,
    input  logic        rsign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misalign_o
);

    logic [31:0] w_shifted;

    assign w_shifted  = rdata_i >> {addr_lo_i, 3'b000};
    assign misalign_o = lsu_misaligned(mask_i, addr_lo_i);

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = wdata_i;
        ldata_o = w_shifted;
        case (mask_i)
            LSU_B: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                ldata_o = {{24{rsign_i & w_shifted[7]}}, w_shifted[7:0]};
            end
            LSU_H: begin
                wstrb_o = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                ldata_o = {{16{rsign_i & w_shifted[15]}}, w_shifted[15:0]};
            end
            LSU_W: begin
                wstrb_o = 4'b1111;
            end
            default: begin
                wstrb_o = 4'b0000;
            end
        endcase
        // Loads never assert byte strobes on the bus
        if (!write_i) begin
            wstrb_o = 4'b0000;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_25040111_lsu.sv
// ============================================================================
//  Module   : ysyx_25040111_lsu
//  Purpose  : Load/store + writeback stage: packet latch, bus FSM, commit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25040111_lsu
    import ysyx_25040111_lsu_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    ysyx_25040111_abt_if.slave   abt,
    ysyx_25040111_mem_if.master  mem,
    output logic                 gpr_wen,
    output logic [GPR_AW-1:0]    gpr_waddr,
    output logic [XLEN-1:0]      gpr_wdata,
    output logic                 csr_wen,
    output logic [CSR_AW-1:0]    csr_waddr,
    output logic [XLEN-1:0]      csr_wdata,
    output logic                 lsu_misalign,
    output logic                 lsu_buserr
);

    lsu_state_e  state_q, state_d;
    lsu_pkt_t    pkt_q, pkt_d;
    logic        fault_q, fault_d;
    logic        buserr_q, buserr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_idle, w_req, w_wb;
    logic        w_accept;
    logic        w_in_memop, w_pkt_memop, w_store;
    logic [1:0]  w_lane_mask, w_lane_addr;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata, w_ldata;
    logic        w_misalign;

    assign w_idle      = (state_q == LSU_IDLE);
    assign w_req       = (state_q == LSU_REQ);
    assign w_wb        = (state_q == LSU_WB);
    assign w_accept    = abt.abt_valid & w_idle;
    assign w_in_memop  = abt.abt_men & (abt.abt_mask != LSU_N);
    assign w_pkt_memop = pkt_q.men & (pkt_q.mask != LSU_N);
    assign w_store     = w_pkt_memop & pkt_q.write;

    // The misalign check must see the incoming packet in IDLE; later states use the latch
    assign w_lane_mask = w_idle ? abt.abt_mask      : pkt_q.mask;
    assign w_lane_addr = w_idle ? abt.abt_addr[1:0] : pkt_q.addr[1:0];

    ysyx_25040111_lsu_align u_align (
        .mask_i     (w_lane_mask),
        .addr_lo_i  (w_lane_addr),
        .write_i    (pkt_q.write),
        .rsign_i    (pkt_q.rsign),
        .wdata_i    (pkt_q.wdata),
        .rdata_i    (rdata_q),
        .wstrb_o    (w_wstrb),
        .wdata_o    (w_wdata),
        .ldata_o    (w_ldata),
        .misalign_o (w_misalign)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= LSU_IDLE;
            pkt_q    <= '0;
            fault_q  <= 1'b0;
            buserr_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            fault_q  <= fault_d;
            buserr_q <= buserr_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        fault_d  = fault_q;
        buserr_d = buserr_q;
        rdata_d  = rdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (w_accept) begin
                    pkt_d.men   = abt.abt_men;
                    pkt_d.ard   = abt.abt_ard;
                    pkt_d.rd    = abt.abt_rd;
                    pkt_d.gen   = abt.abt_gen;
                    pkt_d.acsr  = abt.abt_acsr;
                    pkt_d.csr   = abt.abt_csr;
                    pkt_d.sen   = abt.abt_sen;
                    pkt_d.write = abt.abt_write;
                    pkt_d.addr  = abt.abt_addr;
                    pkt_d.wdata = abt.abt_wdata;
                    pkt_d.mask  = abt.abt_mask;
                    pkt_d.rsign = abt.abt_rsign;
                    fault_d     = w_in_memop & w_misalign;
                    buserr_d    = 1'b0;
                    rdata_d     = '0;
                    state_d     = (w_in_memop & ~w_misalign) ? LSU_REQ : LSU_WB;
                end
            end
            LSU_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                if (mem.mem_resp_valid) begin
                    rdata_d  = mem.mem_rdata;
                    buserr_d = mem.mem_resp_err;
                    state_d  = LSU_WB;
                end
            end
            LSU_WB: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    assign abt.abt_ready  = w_idle;
    assign abt.abt_finish = w_wb;

    // Request fields are only driven while the request is outstanding
    assign mem.mem_req_valid = w_req;
    assign mem.mem_addr      = w_req ? {pkt_q.addr[31:2], 2'b00} : 32'd0;
    assign mem.mem_wen       = w_req & pkt_q.write;
    assign mem.mem_wstrb     = w_req ? w_wstrb : 4'b0000;
    assign mem.mem_wdata     = w_req ? w_wdata : 32'd0;

    assign gpr_wen   = w_wb & pkt_q.gen & (pkt_q.ard != 5'd0) & ~w_store & ~fault_q & ~buserr_q;
    assign gpr_waddr = w_wb ? pkt_q.ard : 5'd0;
    assign gpr_wdata = w_wb ? ((w_pkt_memop & ~pkt_q.write) ? w_ldata : pkt_q.rd) : 32'd0;

    assign csr_wen   = w_wb & pkt_q.sen & ~fault_q;
    assign csr_waddr = w_wb ? pkt_q.acsr : 12'd0;
    assign csr_wdata = w_wb ? pkt_q.csr : 32'd0;

    assign lsu_misalign = w_wb & fault_q;
    assign lsu_buserr   = w_wb & buserr_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040111_lsu.sv
// ============================================================================
//  Module   : tb_ysyx_25040111_lsu
//  Purpose  : Directed and randomized packets against a behavioural LSU model
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25040111_lsu;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_25040111_abt_if abt ();
    ysyx_25040111_mem_if mem ();

    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        lsu_misalign;
    logic        lsu_buserr;

    ysyx_25040111_lsu dut (
        .clock        (clock),
        .reset        (reset),
        .abt          (abt),
        .mem          (mem),
        .gpr_wen      (gpr_wen),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .csr_wen      (csr_wen),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .lsu_misalign (lsu_misalign),
        .lsu_buserr   (lsu_buserr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit        men;
        bit [4:0]  ard;
        bit [31:0] rd;
        bit        gen;
        bit [11:0] acsr;
        bit [31:0] csr;
        bit        sen;
        bit        write;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [1:0]  mask;
        bit        rsign;
        bit [31:0] rdata;
        bit        err;
        int        rdly;
        int        sdly;
        bit        junk;
    } pkt_t;

    function automatic pkt_t blank_pkt();
        pkt_t p;
        p.men = 0; p.ard = 0; p.rd = 0; p.gen = 0; p.acsr = 0; p.csr = 0; p.sen = 0;
        p.write = 0; p.addr = 0; p.wdata = 0; p.mask = 0; p.rsign = 0; p.rdata = 0;
        p.err = 0; p.rdly = 0; p.sdly = 0; p.junk = 0;
        return p;
    endfunction

    // ---- reference model: sizes in bytes, plain arithmetic ----
    function automatic bit m_memop(pkt_t p);
        return p.men && (p.mask != 0);
    endfunction

    function automatic bit m_mis(pkt_t p);
        return ((p.mask == 2) && (p.addr % 2 != 0)) || ((p.mask == 3) && (p.addr % 4 != 0));
    endfunction

    function automatic bit [31:0] m_strb(pkt_t p);
        bit [31:0] off = p.addr % 4;
        if (!p.write) return 0;
        case (p.mask)
            2'd1:    return 32'd1 << off;
            2'd2:    return 32'd3 << off;
            2'd3:    return 32'd15;
            default: return 0;
        endcase
    endfunction

    function automatic bit [31:0] m_wdata(pkt_t p);
        case (p.mask)
            2'd1:    return (p.wdata & 32'hFF) * 32'h01010101;
            2'd2:    return (p.wdata & 32'hFFFF) * 32'h00010001;
            default: return p.wdata;
        endcase
    endfunction

    function automatic bit [31:0] m_load(pkt_t p);
        bit [31:0] r = p.rdata >> (8 * (p.addr % 4));
        bit [31:0] v;
        case (p.mask)
            2'd1: begin
                v = r & 32'hFF;
                if (p.rsign && v >= 128) v = v - 256;
            end
            2'd2: begin
                v = r & 32'hFFFF;
                if (p.rsign && v >= 32768) v = v - 65536;
            end
            default: v = r;
        endcase
        return v;
    endfunction

    task automatic quiet_inputs();
        abt.abt_valid = 0; abt.abt_men = 0; abt.abt_ard = 0; abt.abt_rd = 0;
        abt.abt_gen = 0; abt.abt_acsr = 0; abt.abt_csr = 0; abt.abt_sen = 0;
        abt.abt_write = 0; abt.abt_addr = 0; abt.abt_wdata = 0; abt.abt_mask = 0;
        abt.abt_rsign = 0;
        mem.mem_req_ready = 0; mem.mem_resp_valid = 0; mem.mem_rdata = 0; mem.mem_resp_err = 0;
    endtask

    task automatic drive_pkt(pkt_t p);
        abt.abt_men = p.men; abt.abt_ard = p.ard; abt.abt_rd = p.rd; abt.abt_gen = p.gen;
        abt.abt_acsr = p.acsr; abt.abt_csr = p.csr; abt.abt_sen = p.sen;
        abt.abt_write = p.write; abt.abt_addr = p.addr; abt.abt_wdata = p.wdata;
        abt.abt_mask = p.mask; abt.abt_rsign = p.rsign;
    endtask

    task automatic run_pkt(pkt_t p);
        bit memop = m_memop(p);
        bit fault = memop && m_mis(p);
        bit bus   = memop && !m_mis(p);
        bit store = memop && p.write;
        bit berr  = bus && p.err;
        bit exp_gw = p.gen && (p.ard != 0) && !store && !fault && !berr;
        bit exp_cw = p.sen && !fault;
        bit [31:0] exp_gd = (bus && !p.write) ? m_load(p) : p.rd;

        @(negedge clock);
        chk("ready_idle", 32'(abt.abt_ready), 32'd1);
        drive_pkt(p);
        abt.abt_valid = 1;
        @(posedge clock);
        #1;
        abt.abt_valid = 0;
        // scramble fields so that only latched values can produce correct results
        abt.abt_rd = ~p.rd; abt.abt_addr = ~p.addr; abt.abt_wdata = ~p.wdata;
        abt.abt_ard = ~p.ard; abt.abt_csr = ~p.csr; abt.abt_mask = ~p.mask;
        abt.abt_rsign = ~p.rsign; abt.abt_gen = ~p.gen; abt.abt_sen = ~p.sen;
        if (bus) begin
            for (int i = 0; i <= p.rdly; i++) begin
                @(negedge clock);
                chk("req_valid", 32'(mem.mem_req_valid), 32'd1);
                chk("req_addr", mem.mem_addr, p.addr & 32'hFFFF_FFFC);
                chk("req_wen", 32'(mem.mem_wen), 32'(p.write));
                chk("req_strb", 32'(mem.mem_wstrb), m_strb(p));
                if (store) chk("req_wdata", mem.mem_wdata, m_wdata(p));
                chk("busy_ready", 32'(abt.abt_ready), 32'd0);
                chk("busy_finish", 32'(abt.abt_finish), 32'd0);
                if (i == p.rdly) begin
                    mem.mem_req_ready = 1;
                    if (p.junk) begin
                        mem.mem_resp_valid = 1;
                        mem.mem_rdata = ~p.rdata;
                        mem.mem_resp_err = ~p.err;
                    end
                end
            end
            for (int j = 0; j <= p.sdly; j++) begin
                @(negedge clock);
                mem.mem_req_ready = 0;
                mem.mem_resp_valid = 0;
                chk("resp_reqv", 32'(mem.mem_req_valid), 32'd0);
                chk("resp_finish", 32'(abt.abt_finish), 32'd0);
                if (j == p.sdly) begin
                    mem.mem_resp_valid = 1;
                    mem.mem_rdata = p.rdata;
                    mem.mem_resp_err = p.err;
                end
            end
        end
        @(negedge clock);
        mem.mem_resp_valid = 0;
        mem.mem_rdata = 32'hA5A5_5A5A;
        chk("wb_finish", 32'(abt.abt_finish), 32'd1);
        chk("wb_ready", 32'(abt.abt_ready), 32'd0);
        chk("wb_reqv", 32'(mem.mem_req_valid), 32'd0);
        chk("wb_gwen", 32'(gpr_wen), 32'(exp_gw));
        if (exp_gw) begin
            chk("wb_gaddr", 32'(gpr_waddr), 32'(p.ard));
            chk("wb_gdata", gpr_wdata, exp_gd);
        end
        chk("wb_cwen", 32'(csr_wen), 32'(exp_cw));
        if (exp_cw) begin
            chk("wb_caddr", 32'(csr_waddr), 32'(p.acsr));
            chk("wb_cdata", csr_wdata, p.csr);
        end
        chk("wb_misalign", 32'(lsu_misalign), 32'(fault));
        chk("wb_buserr", 32'(lsu_buserr), 32'(berr));
        @(negedge clock);
        chk("post_ready", 32'(abt.abt_ready), 32'd1);
        chk("post_finish", 32'(abt.abt_finish), 32'd0);
    endtask

    initial begin
        pkt_t p;
        quiet_inputs();
        reset = 1;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(abt.abt_ready), 32'd1);
        chk("rst_finish", 32'(abt.abt_finish), 32'd0);
        chk("rst_reqv", 32'(mem.mem_req_valid), 32'd0);
        chk("rst_addr", mem.mem_addr, 32'd0);
        chk("rst_gwen", 32'(gpr_wen), 32'd0);
        chk("rst_cwen", 32'(csr_wen), 32'd0);
        reset = 0;

        // ALU op
        p = blank_pkt(); p.ard = 5; p.rd = 32'h1234; p.gen = 1;
        run_pkt(p);
        // signed byte load
        p = blank_pkt(); p.men = 1; p.ard = 7; p.gen = 1; p.addr = 32'h8000_0003;
        p.mask = 2'b01; p.rsign = 1; p.rdata = 32'h80FF_0000;
        run_pkt(p);
        // half store with a slow slave
        p = blank_pkt(); p.men = 1; p.ard = 3; p.gen = 1; p.write = 1; p.addr = 32'h8000_0002;
        p.wdata = 32'h1234_ABCD; p.mask = 2'b10; p.rdly = 3;
        run_pkt(p);
        // misaligned word load
        p = blank_pkt(); p.men = 1; p.ard = 9; p.gen = 1; p.addr = 32'h8000_0001; p.mask = 2'b11;
        run_pkt(p);
        // bus error on a load
        p = blank_pkt(); p.men = 1; p.ard = 4; p.gen = 1; p.addr = 32'h8000_0010; p.mask = 2'b11;
        p.rdata = 32'h1111_2222; p.err = 1; p.sdly = 2;
        run_pkt(p);
        // CSR write
        p = blank_pkt(); p.sen = 1; p.acsr = 12'h300; p.csr = 32'hDEAD_BEEF;
        run_pkt(p);

        // reset while waiting for a response
        @(negedge clock);
        abt.abt_valid = 1; abt.abt_men = 1; abt.abt_mask = 2'b11; abt.abt_addr = 32'h100;
        abt.abt_gen = 1; abt.abt_ard = 6;
        @(negedge clock);
        quiet_inputs();
        mem.mem_req_ready = 1;
        @(negedge clock);
        mem.mem_req_ready = 0;
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("abort_ready", 32'(abt.abt_ready), 32'd1);
        chk("abort_finish", 32'(abt.abt_finish), 32'd0);
        chk("abort_reqv", 32'(mem.mem_req_valid), 32'd0);
        mem.mem_resp_valid = 1; mem.mem_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        mem.mem_resp_valid = 0;
        chk("late_finish", 32'(abt.abt_finish), 32'd0);
        chk("late_gwen", 32'(gpr_wen), 32'd0);
        chk("late_ready", 32'(abt.abt_ready), 32'd1);
        @(negedge clock);
        chk("late_finish2", 32'(abt.abt_finish), 32'd0);

        // randomized packets
        for (int n = 0; n < 250; n++) begin
            p = blank_pkt();
            p.men   = ($urandom % 4) != 0;
            p.mask  = 2'($urandom % 4);
            p.addr  = $urandom;
            if ($urandom % 2) p.addr = p.addr & 32'hFFFF_FFFC;
            p.write = m_memop(p) ? 1'($urandom % 2) : 1'b0;
            p.ard   = 5'($urandom % 32);
            p.rd    = $urandom;
            p.gen   = 1'($urandom % 2);
            p.acsr  = 12'($urandom);
            p.csr   = $urandom;
            p.sen   = ($urandom % 4) == 0;
            p.wdata = $urandom;
            p.rsign = 1'($urandom % 2);
            p.rdata = $urandom;
            p.err   = ($urandom % 8) == 0;
            p.rdly  = int'($urandom % 4);
            p.sdly  = int'($urandom % 4);
            p.junk  = ($urandom % 4) == 0;
            run_pkt(p);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
